// File: rtl/mem_access_unit.sv
// Load/store bus adapter: sizes, lane-shifts and extends a single memory access per request.
// Optional MISALIGN_TRAP_EN: misaligned accesses fault without touching the bus instead of being aligned down.
module mem_access_unit (
    input  logic        clk,
    input  logic        arstn,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [2:0]  i_func_3,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_rdata,
    output logic        o_fault,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [63:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [63:0] o_mem_wdata,
    output logic [7:0]  o_mem_be,
    input  logic        i_mem_rvalid,
    input  logic [63:0] i_mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;

    logic [1:0]  req_size;
    logic [2:0]  raw_off;
    logic [2:0]  align_mask;
    logic [2:0]  req_off;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic [63:0] shifted;
    logic [63:0] ext_data;

    assign req_size = i_func_3[1:0];
    assign raw_off  = i_addr[2:0];

    // Offset is forced to natural alignment; in the trap build misaligned requests never reach the bus anyway.
    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            2'd0:    align_mask = 3'b111;
            2'd1:    align_mask = 3'b110;
            2'd2:    align_mask = 3'b100;
            default: align_mask = 3'b000;
        endcase
    end

    assign req_off = raw_off & align_mask;

    always_comb begin
        req_be = 8'hFF;
        case (req_size)
            2'd0:    req_be = 8'h01 << req_off;
            2'd1:    req_be = 8'h03 << req_off;
            2'd2:    req_be = 8'h0F << req_off;
            default: req_be = 8'hFF;
        endcase
    end

    assign req_wdata = i_wdata << {req_off, 3'b000};
    assign shifted   = i_mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_data = shifted;
        case (f3_q)
            3'b000:  ext_data = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  ext_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  ext_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  ext_data = {56'd0, shifted[7:0]};
            3'b101:  ext_data = {48'd0, shifted[15:0]};
            3'b110:  ext_data = {32'd0, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    logic fault_q;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = raw_off[0];
            2'd2:    misalign = |raw_off[1:0];
            default: misalign = |raw_off;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)
            fault_q <= 1'b0;
        else if (state == IDLE && i_req_valid)
            fault_q <= misalign;
    end

    assign o_fault = (state == DONE) & fault_q;
`else
    assign o_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 3'b000;
            o_rdata     <= 64'd0;
            o_mem_addr  <= 64'd0;
            o_mem_wdata <= 64'd0;
            o_mem_be    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q        <= i_req_write;
                        f3_q        <= i_func_3;
                        off_q       <= req_off;
                        o_mem_addr  <= {i_addr[63:3], 3'b000};
                        o_mem_wdata <= req_wdata;
                        o_mem_be    <= req_be;
`ifdef MISALIGN_TRAP_EN
                        state       <= misalign ? DONE : REQ;
`else
                        state       <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (i_mem_ready)
                        state <= we_q ? DONE : RESP;
                end
                RESP: begin
                    if (i_mem_rvalid) begin
                        o_rdata <= ext_data;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_mem_valid = (state == REQ);
    assign o_mem_we    = (state == REQ) & we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, stalls, misalignment and mid-transaction reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_write = 1'b0;
    logic [2:0]  i_func_3 = 3'b000;
    logic [63:0] i_addr = 64'd0;
    logic [63:0] i_wdata = 64'd0;
    logic        o_busy, o_done, o_fault, o_mem_valid, o_mem_we;
    logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_be;
    logic        i_mem_ready = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [63:0] i_mem_rdata = 64'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .arstn(arstn),
        .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_func_3(i_func_3),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_fault(o_fault),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    // Presents a one-cycle request; returns at the negedge of cycle 1.
    task automatic start_req(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        i_req_valid = 1'b1; i_req_write = w; i_func_3 = f3; i_addr = a; i_wdata = d;
        tick();
        i_req_valid = 1'b0;
    endtask

    // Zero-wait load: rvalid in cycle 2, reports o_done as seen in cycle 3.
    task automatic run_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd, output logic done_seen);
        i_mem_ready = 1'b1;
        start_req(1'b0, f3, a, 64'd0);
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = rd;
        tick();
        i_mem_rvalid = 1'b0;
        done_seen = o_done;
        tick();
    endtask

    task automatic test_reset;
        #12;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_fault !== 1'b0) begin
            $display("FAIL reset_flags busy=%b done=%b fault=%b required 0 0 0", o_busy, o_done, o_fault); failures++; end
        checks++; if (o_mem_valid !== 1'b0 || o_mem_we !== 1'b0) begin
            $display("FAIL reset_bus valid=%b we=%b required 0 0", o_mem_valid, o_mem_we); failures++; end
        checks++; if (o_rdata !== 64'd0 || o_mem_addr !== 64'd0 || o_mem_wdata !== 64'd0 || o_mem_be !== 8'd0) begin
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%h required zeros", o_rdata, o_mem_addr, o_mem_wdata, o_mem_be); failures++; end
        tick();
        arstn = 1'b1;
        tick();
    endtask

    task automatic test_store_word;
        i_mem_ready = 1'b1;
        start_req(1'b1, 3'b010, 64'h1004, 64'hDEADBEEF);
        checks++; if (o_mem_valid !== 1'b1 || o_mem_we !== 1'b1) begin
            $display("FAIL sw_valid valid=%b we=%b required 1 1", o_mem_valid, o_mem_we); failures++; end
        checks++; if (o_mem_addr !== 64'h1000) begin
            $display("FAIL sw_addr got=%h required 1000", o_mem_addr); failures++; end
        checks++; if (o_mem_be !== 8'hF0) begin
            $display("FAIL sw_be got=%h required f0", o_mem_be); failures++; end
        checks++; if (o_mem_wdata !== 64'hDEADBEEF_00000000) begin
            $display("FAIL sw_wdata got=%h required deadbeef00000000", o_mem_wdata); failures++; end
        tick();
        checks++; if (o_done !== 1'b1 || o_fault !== 1'b0) begin
            $display("FAIL sw_done_c2 done=%b fault=%b required 1 0", o_done, o_fault); failures++; end
        tick();
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL sw_idle done=%b busy=%b required 0 0", o_done, o_busy); failures++; end
    endtask

    task automatic test_load_byte_wait;
        i_mem_ready = 1'b1;
        start_req(1'b0, 3'b000, 64'h2003, 64'd0);
        checks++; if (o_mem_valid !== 1'b1 || o_mem_we !== 1'b0 || o_mem_be !== 8'h08 || o_mem_addr !== 64'h2000) begin
            $display("FAIL lb_req valid=%b we=%b be=%h addr=%h required 1 0 08 2000", o_mem_valid, o_mem_we, o_mem_be, o_mem_addr); failures++; end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_busy !== 1'b1 || o_mem_valid !== 1'b0 || o_done !== 1'b0) begin
                $display("FAIL lb_resp_wait cyc=%0d busy=%b valid=%b done=%b required 1 0 0", i + 2, o_busy, o_mem_valid, o_done); failures++; end
            tick();
        end
        i_mem_rvalid = 1'b1; i_mem_rdata = 64'h00000000_80000000;
        checks++; if (o_busy !== 1'b1) begin
            $display("FAIL lb_busy_c5 got=%b required 1", o_busy); failures++; end
        tick();
        i_mem_rvalid = 1'b0;
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b1 || o_rdata !== 64'hFFFFFFFF_FFFFFF80) begin
            $display("FAIL lb_done done=%b busy=%b rdata=%h required 1 1 ffffffffffffff80", o_done, o_busy, o_rdata); failures++; end
        tick();
        checks++; if (o_busy !== 1'b0) begin
            $display("FAIL lb_idle busy=%b required 0", o_busy); failures++; end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3_t [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b011, 3'b111, 3'b100, 3'b101};
        logic [63:0] a_t  [8] = '{64'h2000, 64'h2002, 64'h2004, 64'h2004, 64'h2000, 64'h2000, 64'h2001, 64'h2006};
        logic [63:0] rd_t [8] = '{64'h7F, 64'h80010000, 64'h89ABCDEF_00000000, 64'h89ABCDEF_00000000,
                                  64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210, 64'hF000, 64'hABCD0000_00000000};
        logic [63:0] ex_t [8] = '{64'h7F, 64'hFFFFFFFF_FFFF8001, 64'hFFFFFFFF_89ABCDEF, 64'h00000000_89ABCDEF,
                                  64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210, 64'hF0, 64'hABCD};
        logic done_seen;
        for (int i = 0; i < 8; i++) begin
            run_load(f3_t[i], a_t[i], rd_t[i], done_seen);
            checks++; if (done_seen !== 1'b1 || o_rdata !== ex_t[i]) begin
                $display("FAIL load_ext idx=%0d done=%b rdata=%h required 1 %h", i, done_seen, o_rdata, ex_t[i]); failures++; end
        end
        // SD after the LHU must leave the load result alone
        i_mem_ready = 1'b1;
        start_req(1'b1, 3'b011, 64'h2008, 64'h11223344_55667788);
        checks++; if (o_mem_be !== 8'hFF || o_mem_addr !== 64'h2008 || o_mem_wdata !== 64'h11223344_55667788) begin
            $display("FAIL sd_bus be=%h addr=%h wdata=%h required ff 2008 1122334455667788", o_mem_be, o_mem_addr, o_mem_wdata); failures++; end
        tick();
        checks++; if (o_done !== 1'b1 || o_rdata !== 64'hABCD) begin
            $display("FAIL sd_keeps_rdata done=%b rdata=%h required 1 000000000000abcd", o_done, o_rdata); failures++; end
        tick();
    endtask

    task automatic test_stall;
        i_mem_ready = 1'b0;
        start_req(1'b1, 3'b000, 64'h4005, 64'h5A);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) i_mem_ready = 1'b1;
            checks++; if (o_mem_valid !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 64'h4000 ||
                          o_mem_be !== 8'h20 || o_mem_wdata !== 64'h00005A00_00000000 || o_done !== 1'b0) begin
                $display("FAIL stall_hold cyc=%0d valid=%b we=%b addr=%h be=%h wdata=%h done=%b", i + 1,
                         o_mem_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_done); failures++; end
            i_req_valid = 1'b1; i_req_write = 1'b0; i_func_3 = 3'b011; i_addr = 64'h9000;
            tick();
        end
        i_req_valid = 1'b0;
        checks++; if (o_done !== 1'b1) begin
            $display("FAIL stall_done got=%b required 1", o_done); failures++; end
        tick();
        checks++; if (o_busy !== 1'b0 || o_mem_valid !== 1'b0 || o_mem_addr !== 64'h4000) begin
            $display("FAIL stall_ignored busy=%b valid=%b addr=%h required 0 0 4000", o_busy, o_mem_valid, o_mem_addr); failures++; end
    endtask

    task automatic test_misalign;
        i_mem_ready = 1'b1;
        start_req(1'b0, 3'b010, 64'h3002, 64'd0);
`ifdef MISALIGN_TRAP_EN
        checks++; if (o_mem_valid !== 1'b0 || o_done !== 1'b1 || o_fault !== 1'b1) begin
            $display("FAIL trap_c1 valid=%b done=%b fault=%b required 0 1 1", o_mem_valid, o_done, o_fault); failures++; end
        checks++; if (o_rdata !== 64'hABCD) begin
            $display("FAIL trap_rdata got=%h required 000000000000abcd", o_rdata); failures++; end
        tick();
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_fault !== 1'b0) begin
            $display("FAIL trap_idle done=%b busy=%b fault=%b required 0 0 0", o_done, o_busy, o_fault); failures++; end
`else
        checks++; if (o_mem_valid !== 1'b1 || o_mem_be !== 8'h0F || o_mem_addr !== 64'h3000) begin
            $display("FAIL mask_req valid=%b be=%h addr=%h required 1 0f 3000", o_mem_valid, o_mem_be, o_mem_addr); failures++; end
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 64'h11223344_8899AABB;
        tick();
        i_mem_rvalid = 1'b0;
        checks++; if (o_done !== 1'b1 || o_fault !== 1'b0 || o_rdata !== 64'hFFFFFFFF_8899AABB) begin
            $display("FAIL mask_done done=%b fault=%b rdata=%h required 1 0 ffffffff8899aabb", o_done, o_fault, o_rdata); failures++; end
        tick();
`endif
    endtask

    task automatic test_reset_mid;
        i_mem_ready = 1'b1;
        start_req(1'b0, 3'b011, 64'h5000, 64'd0);
        tick();
        checks++; if (o_busy !== 1'b1 || o_mem_valid !== 1'b0) begin
            $display("FAIL rst_mid_resp busy=%b valid=%b required 1 0", o_busy, o_mem_valid); failures++; end
        #2 arstn = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0 || o_mem_valid !== 1'b0 || o_rdata !== 64'd0) begin
            $display("FAIL rst_mid_async busy=%b valid=%b rdata=%h required 0 0 0", o_busy, o_mem_valid, o_rdata); failures++; end
        tick();
        arstn = 1'b1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 64'hCAFE;
        tick();
        i_mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rdata !== 64'd0) begin
                $display("FAIL rst_late_rvalid cyc=%0d done=%b busy=%b rdata=%h required 0 0 0", i, o_done, o_busy, o_rdata); failures++; end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte_wait();
        test_load_ext();
        test_stall();
        test_misalign();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  clock, rising edge.
REQ-002 arstn  in  1  reset, asynchronous, active-low.
REQ-003 i_req_valid  in  1  access request pulse from the control FSM, sampled only in IDLE.
REQ-004 i_req_write  in  1  1 = store, 0 = load.
REQ-005 i_func_3  in  3  size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 = D.
REQ-006 i_addr  in  64  byte address.
REQ-007 i_wdata  in  64  store data, right-aligned.
REQ-008 o_busy  out  1  high in every state except IDLE.
REQ-009 o_done  out  1  one-cycle completion pulse.
REQ-010 o_rdata  out  64  extended load result, held until the next load completes.
REQ-011 o_fault  out  1  misaligned-access flag, valid only with o_done.
REQ-012 o_mem_valid  out  1  bus request valid.
REQ-013 i_mem_ready  in  1  bus request accepted.
REQ-014 o_mem_addr  out  64  {addr[63:3], 3'b000}.
REQ-015 o_mem_we  out  1  bus write.
REQ-016 o_mem_wdata  out  64  lane-shifted store data.
REQ-017 o_mem_be  out  8  byte enables.
REQ-018 i_mem_rvalid  in  1  read data valid.
REQ-019 i_mem_rdata  in  64  read data, 8-byte aligned word.

Function
REQ-020 FSM states: IDLE, REQ, RESP, DONE.
REQ-021 IDLE + i_req_valid: latch i_req_write, i_func_3, i_addr, i_wdata, then go to REQ. i_req_valid is ignored in all other states.
REQ-022 REQ: assert o_mem_valid. Hold o_mem_addr/we/wdata/be stable until i_mem_ready. On handshake, a store goes to DONE and a load goes to RESP.
REQ-023 RESP: o_mem_valid low. Wait any number of cycles for i_mem_rvalid, then capture the extended data into o_rdata and go to DONE. i_mem_rvalid is ignored in every state except RESP.
REQ-024 DONE: o_done = 1 for exactly one cycle, then IDLE.
REQ-025 Minimum latency with zero-wait bus: store is request at cycle 0, DONE at cycle 2. Load is request at cycle 0, RESP at cycle 2 with rvalid, DONE at cycle 3.
REQ-026 off = addr[2:0]. Byte enables by size: B is 8'h01<<off, H is 8'h03<<off, W is 8'h0F<<off, D is 8'hFF.
REQ-027 o_mem_wdata = wdata << (8*off). Stores use only func3[1:0].
REQ-028 Load data: shift i_mem_rdata right by 8*off, truncate to size, then extend. B/H/W/D sign-extend to 64 bits; BU/HU/WU zero-extend.
REQ-029 A store never updates o_rdata. A faulting access never updates o_rdata.
REQ-030 Misaligned access means H with off[0]≠0, W with off[1:0]≠0, or D with off≠0. Its handling is defined in Configuration.

Reset
REQ-031 Reset is asynchronous and immediate. State goes to IDLE. o_busy, o_done, o_fault, o_mem_valid and o_mem_we go to 0. o_rdata, o_mem_addr, o_mem_wdata and o_mem_be go to 0.
REQ-032 A reset mid-transaction abandons the transaction and drops o_mem_valid in the same instant. A late i_mem_rvalid after reset is ignored.

Configuration
REQ-033 Macro MISALIGN_TRAP_EN.
REQ-034 Defined: a misaligned request goes IDLE→DONE with no bus transaction (o_mem_valid never asserts). o_fault = 1 together with o_done.
REQ-035 Undefined: offset is masked to natural alignment (off & ~(size−1)) before lane/shift computation and the access proceeds normally. o_fault is tied 0. The port exists in both builds.

Verification
REQ-036 SW addr 0x1004, wdata 0xDEADBEEF, ready at first REQ cycle -> o_mem_addr 0x1000, be 0xF0, wdata 0xDEADBEEF_00000000, o_done at cycle 2.
REQ-037 LB addr 0x2003, rdata 0x00000000_80000000 returned 4 cycles after acceptance -> o_rdata 0xFFFFFFFF_FFFFFF80. o_busy is high throughout.
REQ-038 LHU addr 0x2006, rdata 0xABCD0000_00000000 -> o_rdata 0x00000000_0000ABCD. A following SD leaves o_rdata unchanged.
REQ-039 i_mem_ready held low 5 cycles in REQ -> o_mem_* stable for all 6 cycles. A second i_req_valid during the transaction is ignored.
REQ-040 LW addr 0x3002 -> with MISALIGN_TRAP_EN: no o_mem_valid, o_done with o_fault 1 at cycle 1. Without it: be 0x0F, addr 0x3000, o_fault 0.
REQ-041 arstn asserted in RESP, then rvalid after release -> IDLE, no o_done, o_rdata 0.
